// File: rtl/conv_pkg.sv
// Shared constants and elaboration helpers for the convolution MAC family.
// Saturation helper is shared by every variant's final stage.
package conv_pkg;

    localparam int CH    = 3;
    localparam int K     = 5;
    localparam int DW    = 12;
    localparam int WW    = 8;
    localparam int OW    = 14;
    localparam int SHIFT = 7;

    function automatic int clog2ceil(input int n);
        int d;
        d = 0;
        for (int i = 0; i < 31; i++) begin
            d = ((32'sd1 <<< i) < n) ? (i + 1) : d;
        end
        return d;
    endfunction

    // Number of nodes at tree level l (level 0 = the leaves).
    function automatic int level_cnt(input int n, input int l);
        return (n + (32'sd1 <<< l) - 1) >>> l;
    endfunction

    function automatic int level_off(input int n, input int l);
        int s;
        s = 0;
        for (int k = 0; k < 32; k++) begin
            s = (k < l) ? (s + level_cnt(n, k)) : s;
        end
        return s;
    endfunction

    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/conv_adder_tree.sv
// Registered binary reduction tree; one register level per tree depth,
// odd leftovers are forwarded through a register at their level.
module conv_adder_tree #(
    parameter int   N   = 75,
    parameter int   IW  = 20,
    localparam int  D   = conv_pkg::clog2ceil(N),
    localparam int  OWT = IW + D
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  in_valid,
    input  logic [N*IW-1:0]       in_data,
    output logic [D-1:0]          lvl_valid,
    output logic                  out_valid,
    output logic signed [OWT-1:0] out_data
);
    import conv_pkg::*;

    localparam int TOT = level_off(N, D + 1);
    localparam int NR  = TOT - N;

    logic signed [OWT-1:0] all_s  [TOT];
    logic signed [OWT-1:0] node_s [NR];
    logic signed [OWT-1:0] node_r [NR];
    logic [D-1:0]          valid_r;

    // Flat view of every node: sign-extended leaves followed by the registered levels.
    always_comb begin
        for (int j = 0; j < N; j++) begin
            all_s[j] = OWT'(signed'(in_data[j*IW +: IW]));
        end
        for (int j = 0; j < NR; j++) begin
            all_s[N + j] = node_r[j];
        end
    end

    for (genvar gl = 1; gl <= D; gl++) begin : g_lvl
        localparam int NI  = level_cnt(N, gl - 1);
        localparam int NO  = level_cnt(N, gl);
        localparam int SRC = level_off(N, gl - 1);
        localparam int DST = level_off(N, gl) - N;
        for (genvar gi = 0; gi < NO; gi++) begin : g_node
            if (2 * gi + 1 < NI) begin : g_add
                assign node_s[DST + gi] = all_s[SRC + 2*gi] + all_s[SRC + 2*gi + 1];
            end else begin : g_pass
                assign node_s[DST + gi] = all_s[SRC + 2*gi];
            end
        end
    end

    // All levels and their valid bits advance together only when enabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
            for (int j = 0; j < NR; j++) begin
                node_r[j] <= '0;
            end
        end else if (en) begin
            valid_r[0] <= in_valid;
            for (int l = 1; l < D; l++) begin
                valid_r[l] <= valid_r[l-1];
            end
            for (int j = 0; j < NR; j++) begin
                node_r[j] <= node_s[j];
            end
        end
    end

    assign lvl_valid = valid_r;
    assign out_valid = valid_r[D-1];
    assign out_data  = all_s[TOT-1];

endmodule

// File: rtl/conv_mac_param.sv
// Multi-channel KxK convolution MAC: per-tap multiply, registered adder tree,
// bias/shift/saturate/ReLU final stage, with a stallable ready/valid pipeline.
module conv_mac_param #(
    parameter int  CH    = conv_pkg::CH,
    parameter int  K     = conv_pkg::K,
    parameter int  DW    = conv_pkg::DW,
    parameter int  WW    = conv_pkg::WW,
    parameter int  OW    = conv_pkg::OW,
    parameter int  SHIFT = conv_pkg::SHIFT,
    localparam int T     = K * K,
    localparam int N     = CH * T,
    localparam int AW    = $clog2(N + 1),
    localparam int WDW   = (WW > OW) ? WW : OW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*DW-1:0]      in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data,
    input  logic                 relu_en,
    input  logic                 w_we,
    input  logic [AW-1:0]        w_addr,
    input  logic [WDW-1:0]       w_data,
    output logic                 busy,
    output logic                 w_err
);
    import conv_pkg::*;

    localparam int D    = clog2ceil(N);
    localparam int PW   = DW + WW;
    localparam int ACCW = PW + D;

    logic                   en_s;
    logic                   busy_s;
    logic                   s0_valid_r;
    logic [N*DW-1:0]        s0_data_r;
    logic                   s1_valid_r;
    logic [N*PW-1:0]        prod_r;
    logic signed [PW-1:0]   prod_s [N];
    logic [D-1:0]           tree_lvl_valid_s;
    logic                   tree_valid_s;
    logic signed [ACCW-1:0] tree_sum_s;
    logic signed [ACCW-1:0] shifted_s;
    logic signed [63:0]     biased_s;
    logic signed [63:0]     sat_s;
    logic signed [OW-1:0]   final_s;
    logic                   out_valid_r;
    logic signed [OW-1:0]   out_data_r;
    logic signed [WW-1:0]   weight_r [N];
    logic signed [OW-1:0]   bias_r;
    logic                   w_err_r;

    assign en_s     = !out_valid_r || out_ready;
    assign busy_s   = s0_valid_r || s1_valid_r || (|tree_lvl_valid_s) || out_valid_r;
    assign in_ready = en_s;
    assign busy     = busy_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign w_err     = w_err_r;

    // Per-tap products against the live weight store.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            prod_s[i] = PW'(signed'(s0_data_r[i*DW +: DW])) * PW'(weight_r[i]);
        end
    end

    conv_adder_tree #(
        .N  (N),
        .IW (PW)
    ) u_tree (
        .clk       (clk),
        .rst       (rst),
        .en        (en_s),
        .in_valid  (s1_valid_r),
        .in_data   (prod_r),
        .lvl_valid (tree_lvl_valid_s),
        .out_valid (tree_valid_s),
        .out_data  (tree_sum_s)
    );

    // Floor shift, bias, saturate, then optional ReLU.
    always_comb begin
        shifted_s = tree_sum_s >>> SHIFT;
        biased_s  = 64'(shifted_s) + 64'(bias_r);
        sat_s     = sat_signed(biased_s, OW);
        if (relu_en && sat_s[63]) begin
            final_s = '0;
        end else begin
            final_s = OW'(sat_s);
        end
    end

    // Input, multiply and final stages; all hold while downstream stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0_valid_r  <= 1'b0;
            s0_data_r   <= '0;
            s1_valid_r  <= 1'b0;
            prod_r      <= '0;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
        end else if (en_s) begin
            s0_valid_r <= in_valid;
            if (in_valid) begin
                s0_data_r <= in_data;
            end
            s1_valid_r <= s0_valid_r;
            for (int i = 0; i < N; i++) begin
                prod_r[i*PW +: PW] <= prod_s[i];
            end
            out_valid_r <= tree_valid_s;
            if (tree_valid_s) begin
                out_data_r <= final_s;
            end
        end
    end

    // Coefficient store: writes only land while the pipeline is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) begin
                weight_r[i] <= '0;
            end
            bias_r  <= '0;
            w_err_r <= 1'b0;
        end else begin
            w_err_r <= 1'b0;
            if (w_we) begin
                if (busy_s || (w_addr > AW'(N))) begin
                    w_err_r <= 1'b1;
                end else if (w_addr == AW'(N)) begin
                    bias_r <= OW'(w_data);
                end else begin
                    weight_r[w_addr] <= WW'(w_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_mac_param.sv
// Directed bench for conv_mac_param with hand-computed results.
module tb_conv_mac_param;

    localparam int CH  = 3;
    localparam int K   = 5;
    localparam int DW  = 12;
    localparam int OW  = 14;
    localparam int N   = CH * K * K;
    localparam int AW  = 7;
    localparam int WDW = 14;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [N*DW-1:0]      in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic signed [OW-1:0] out_data;
    logic                 relu_en = 1'b0;
    logic                 w_we = 1'b0;
    logic [AW-1:0]        w_addr = '0;
    logic [WDW-1:0]       w_data = '0;
    logic                 busy;
    logic                 w_err;

    int n_checks = 0;
    int n_fail   = 0;

    conv_mac_param dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .relu_en   (relu_en),
        .w_we      (w_we),
        .w_addr    (w_addr),
        .w_data    (w_data),
        .busy      (busy),
        .w_err     (w_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic set_taps(input logic [DW-1:0] tap);
        for (int i = 0; i < N; i++) begin
            in_data[i*DW +: DW] = tap;
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [WDW-1:0] data);
        w_we   = 1'b1;
        w_addr = addr;
        w_data = data;
        tick();
        w_we = 1'b0;
    endtask

    task automatic load(input int wv, input int bias);
        for (int i = 0; i < N; i++) begin
            wr(AW'(i), WDW'(wv));
        end
        wr(AW'(N), WDW'(bias));
    endtask

    // One isolated beat; optionally attempts a weight write while it is in flight.
    task automatic run_beat(input logic [DW-1:0] tap, input int expv, input string tag,
                            input bit wr_mid);
        int lat;
        set_taps(tap);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 1;
        chk({tag, "_busy_hi"}, 32'(busy), 32'sd1);
        if (wr_mid) begin
            w_we   = 1'b1;
            w_addr = '0;
            w_data = 14'd5;
            tick();
            w_we = 1'b0;
            lat++;
            chk({tag, "_werr_busy"}, 32'(w_err), 32'sd1);
        end
        while (!out_valid && lat < 40) begin
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, 32'sd10);
        chk({tag, "_data"}, 32'($signed(out_data)), expv);
        tick();
        chk({tag, "_busy_lo"}, 32'(busy), 32'sd0);
    endtask

    function automatic int bp_exp(input int i);
        return ((75 * i) >>> 7) - 3;
    endfunction

    initial begin
        int sent;
        int got;
        int cyc;
        int nv;
        logic exp_rdy;

        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'sd0);
        chk("rst_out_data", 32'($signed(out_data)), 32'sd0);
        chk("rst_busy", 32'(busy), 32'sd0);
        chk("rst_w_err", 32'(w_err), 32'sd0);
        chk("rst_in_ready", 32'(in_ready), 32'sd1);
        rst = 1'b0;
        tick();

        load(1, -3);
        chk("load_no_err", 32'(w_err), 32'sd0);
        run_beat(12'd128, 72, "basic", 1'b0);

        load(127, -3);
        run_beat(12'd2047, 8191, "sat_pos", 1'b0);
        load(-128, -3);
        run_beat(12'd2047, -8192, "sat_neg", 1'b0);

        load(-1, -3);
        run_beat(12'd128, -78, "relu_off", 1'b0);
        relu_en = 1'b1;
        run_beat(12'd128, 0, "relu_on", 1'b0);
        relu_en = 1'b0;

        // Backpressure: 30 back-to-back beats, out_ready low for cycles 12..26.
        load(1, -3);
        sent = 0;
        got  = 0;
        cyc  = 0;
        while (got < 30 && cyc < 200) begin
            out_ready = !(cyc >= 12 && cyc < 27);
            in_valid  = (sent < 30);
            set_taps(DW'(sent));
            #1;
            exp_rdy = !(cyc >= 12 && cyc < 27);
            chk("bp_in_ready", 32'(in_ready), 32'(exp_rdy));
            if (out_valid) begin
                chk(out_ready ? "bp_data" : "bp_hold", 32'($signed(out_data)), bp_exp(got));
                if (out_ready) begin
                    got++;
                end
            end
            if (in_valid && exp_rdy) begin
                sent++;
            end
            tick();
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp_count", got, 32'sd30);
        tick();
        chk("bp_idle", 32'(busy), 32'sd0);

        // Write rules.
        run_beat(12'd128, 72, "wr_busy", 1'b1);
        chk("werr_pulse_end", 32'(w_err), 32'sd0);
        wr(7'd76, 14'd1);
        chk("werr_addr", 32'(w_err), 32'sd1);
        tick();
        chk("werr_addr_end", 32'(w_err), 32'sd0);
        wr(7'd0, 14'd5);
        chk("wr_idle_ok", 32'(w_err), 32'sd0);
        run_beat(12'd128, 76, "wr_idle", 1'b0);

        // Reset with five beats in flight.
        for (int i = 0; i < 5; i++) begin
            set_taps(DW'(i + 1));
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'sd0);
        chk("mid_rst_in_ready", 32'(in_ready), 32'sd1);
        nv = 0;
        for (int i = 0; i < 15; i++) begin
            if (out_valid) begin
                nv++;
            end
            tick();
        end
        chk("mid_rst_no_out", nv, 32'sd0);
        run_beat(12'd128, 0, "post_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
